// File: rtl/modsq_pkg.sv
// Shared types and widths for the modular-squaring result normalizer.
//   WORD_LEN            radix of the packed output words
//   BIT_LEN             significant bits per redundant input coefficient
//   REDUNDANT_ELEMENTS  extra high coefficients beyond MOD_LEN/WORD_LEN
//   SQ_LANE_BITS        physical width of one input lane
//   CARRY_LEN           carry width between coefficients (max carry value 2)
package modsq_pkg;

    localparam int unsigned WORD_LEN           = 16;
    localparam int unsigned BIT_LEN            = 17;
    localparam int unsigned REDUNDANT_ELEMENTS = 2;
    localparam int unsigned SQ_LANE_BITS       = 32;
    localparam int unsigned CARRY_LEN          = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } norm_state_e;

    typedef logic [BIT_LEN-1:0]   coef_t;
    typedef logic [WORD_LEN-1:0]  word_t;
    typedef logic [CARRY_LEN-1:0] carry_t;

endpackage

// File: rtl/modsq_carry_cell.sv
// One carry-propagation step: coef + carry_in split into a radix word and the
// carry into the next coefficient.
//   coef         in   BIT_LEN     redundant coefficient
//   carry_in     in   CARRY_LEN   carry from the lower coefficient
//   word_c       out  WORD_LEN    normalized word (combinational)
//   carry_out_c  out  CARRY_LEN   carry to the next coefficient (combinational)
module modsq_carry_cell
    import modsq_pkg::*;
(
    input  coef_t  coef,
    input  carry_t carry_in,
    output word_t  word_c,
    output carry_t carry_out_c
);

    localparam int unsigned ACC_LEN = BIT_LEN + 1;

    logic [ACC_LEN-1:0] acc_c;

    // Max acc is (2^BIT_LEN - 1) + 2, so the carry never exceeds 2.
    assign acc_c       = ACC_LEN'(coef) + ACC_LEN'(carry_in);
    assign word_c      = acc_c[WORD_LEN-1:0];
    assign carry_out_c = CARRY_LEN'(acc_c >> WORD_LEN);

endmodule

// File: rtl/modsq_result_normalizer.sv
// Serial carry normalizer: captures a redundant coefficient vector, resolves
// carries one coefficient per cycle, and holds the packed result on a
// valid/ready interface.
//   clk, reset   clock, synchronous active-high reset
//   sq_out       redundant coefficients, lane j = sq_out[j*32 +: 32]
//   in_valid     single-cycle capture strobe
//   out_data     packed result, word j = out_data[j*16 +: 16]
//   carry_out    carry left above the top word
//   out_valid    result held until out_ready
//   out_ready    consumer accept
//   busy         normalizing or holding a result
//   drop_err     sticky: an in_valid arrived while it could not be taken
module modsq_result_normalizer
    import modsq_pkg::*;
#(
    parameter  int unsigned MOD_LEN               = 1024,
    localparam int unsigned NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
    localparam int unsigned NUM_ELEMENTS          = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
    localparam int unsigned SQ_OUT_BITS           = NUM_ELEMENTS * 2 * WORD_LEN
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [SQ_OUT_BITS-1:0]           sq_out,
    input  logic                             in_valid,
    output logic [NUM_ELEMENTS*WORD_LEN-1:0] out_data,
    output logic [CARRY_LEN-1:0]             carry_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             drop_err
);

    localparam int unsigned IDX_W   = $clog2(NUM_ELEMENTS);
    localparam int unsigned HI_BITS = SQ_LANE_BITS - BIT_LEN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

    norm_state_e state, next_state;

    coef_t            lane_coef [NUM_ELEMENTS];
    coef_t            coefs     [NUM_ELEMENTS];
    word_t            words     [NUM_ELEMENTS];
    logic [IDX_W-1:0] idx;
    carry_t           carry;

    logic   load_c, step_c, last_c, drop_c;
    word_t  cell_word_c;
    carry_t cell_carry_c;

    logic [NUM_ELEMENTS*HI_BITS-1:0] lane_hi_unused;

    // Lane slicing and output packing; upper lane bits are intentionally dropped.
    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_lane
        assign lane_coef[j] = sq_out[j*SQ_LANE_BITS +: BIT_LEN];
        assign lane_hi_unused[j*HI_BITS +: HI_BITS] = sq_out[j*SQ_LANE_BITS+BIT_LEN +: HI_BITS];
        assign out_data[j*WORD_LEN +: WORD_LEN] = words[j];
    end

    // The lowest unprocessed coefficient always sits in coefs[0].
    modsq_carry_cell u_cell (
        .coef        (coefs[0]),
        .carry_in    (carry),
        .word_c      (cell_word_c),
        .carry_out_c (cell_carry_c)
    );

    assign last_c = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and control decode.
    always_comb begin
        next_state = state;
        load_c     = 1'b0;
        step_c     = 1'b0;
        drop_c     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load_c     = 1'b1;
                    next_state = NORM;
                end
            end
            NORM: begin
                step_c = 1'b1;
                drop_c = in_valid;
                if (last_c) next_state = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    // Accept and relatch in the same cycle: no bubble between results.
                    if (in_valid) begin
                        load_c     = 1'b1;
                        next_state = NORM;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    drop_c = in_valid;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Status outputs, sweep counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            drop_err  <= 1'b0;
            carry_out <= '0;
            carry     <= '0;
            idx       <= '0;
            for (int j = 0; j < NUM_ELEMENTS; j++) words[j] <= '0;
        end else begin
            out_valid <= (next_state == HOLD);
            busy      <= (next_state != IDLE);
            if (drop_c) drop_err <= 1'b1;
            if (load_c) begin
                carry <= '0;
                idx   <= '0;
            end else if (step_c) begin
                words[idx] <= cell_word_c;
                carry      <= cell_carry_c;
                if (last_c) begin
                    carry_out <= cell_carry_c;
                    idx       <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Coefficient shift register; contents are don't-care outside a sweep.
    always_ff @(posedge clk) begin
        if (load_c) begin
            for (int j = 0; j < NUM_ELEMENTS; j++) coefs[j] <= lane_coef[j];
        end else if (step_c) begin
            for (int j = 0; j < NUM_ELEMENTS - 1; j++) coefs[j] <= coefs[j+1];
            coefs[NUM_ELEMENTS-1] <= '0;
        end
    end

endmodule

// File: tb/tb_modsq_result_normalizer.sv
// Scoreboard bench for modsq_result_normalizer: the driver pushes the
// big-integer expected value of every accepted vector; a monitor compares
// whenever out_valid is high and checks latency and hand-off.
module tb_modsq_result_normalizer;

    localparam int NUM  = 66;
    localparam int DW   = NUM * 16;
    localparam int TOT  = DW + 2;
    localparam int LAT  = NUM + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    carry;
        int            due;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM*32-1:0] sq_out;
    logic              in_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        carry_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              drop_err;

    modsq_result_normalizer dut (
        .clk       (clk),
        .reset     (reset),
        .sq_out    (sq_out),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .carry_out (carry_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [31:0] lanes [NUM];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    task automatic check_data(input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int j = 0; j < NUM; j++) begin
                if (act[j*16 +: 16] !== exp[j*16 +: 16]) begin
                    $display("FAIL data word %0d: got 0x%04h expected 0x%04h (cycle %0d)",
                             j, act[j*16 +: 16], exp[j*16 +: 16], cyc);
                    break;
                end
            end
        end
    endtask

    // Reference: the result is the plain integer sum of coef_j * 2^(16*j).
    function automatic exp_t model(input int due);
        logic [TOT-1:0] total;
        exp_t e;
        total = '0;
        for (int j = 0; j < NUM; j++)
            total = total + (TOT'(lanes[j] & 32'h0001_FFFF) << (16 * j));
        e.data  = total[DW-1:0];
        e.carry = total[TOT-1:DW];
        e.due   = due;
        return e;
    endfunction

    // One-cycle in_valid pulse with the current lanes; records expectation if accepted.
    task automatic send(input bit accept);
        @(posedge clk); #1;
        for (int j = 0; j < NUM; j++) sq_out[j*32 +: 32] = lanes[j];
        in_valid = 1'b1;
        if (accept) sb.push_back(model(cyc + LAT));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_ready);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
        out_ready = 1'b1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        if (!out_valid) fail_now("wait_valid_timeout");
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic set_lanes_zero();
        for (int j = 0; j < NUM; j++) lanes[j] = 32'h0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: compare the held result against the scoreboard head.
    bit prev_valid = 1'b0;
    bit prev_hs    = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) check("valid_fall", 64'(out_valid), 64'd0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    fail_now("spurious_valid");
                end else begin
                    if (!prev_valid) check("latency_cycle", 64'(cyc), 64'(sb[0].due));
                    check_data(out_data, sb[0].data);
                    check("carry_out", 64'(carry_out), 64'(sb[0].carry));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sq_out    = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop_err", 64'(drop_err), 64'd0);
        check("rst_out_data_zero", 64'(out_data == '0), 64'd1);
        check("rst_carry_out", 64'(carry_out), 64'd0);

        // Single saturated low lane.
        set_lanes_zero();
        lanes[0] = 32'h0001_FFFF;
        send(1'b1);
        @(negedge clk);
        check("busy_in_norm", 64'(busy), 64'd1);
        drain(1'b0);

        // Every lane saturated: carry ripples through the top.
        for (int j = 0; j < NUM; j++) lanes[j] = 32'h0001_FFFF;
        send(1'b1);
        drain(1'b0);

        // Upper lane bits must be ignored.
        for (int j = 0; j < NUM; j++) lanes[j] = 32'hFFFE_0000 | 32'(j);
        send(1'b1);
        drain(1'b0);

        // Random vectors with random consumer back-pressure.
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < NUM; j++) lanes[j] = $urandom;
            send(1'b1);
            drain(1'b1);
        end
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("no_drop_yet", 64'(drop_err), 64'd0);

        // Drop during NORM, then reset mid-sweep aborts everything.
        for (int j = 0; j < NUM; j++) lanes[j] = $urandom;
        send(1'b1);
        t = cyc - 1;
        goto_cycle(t + 10);
        for (int j = 0; j < NUM; j++) sq_out[j*32 +: 32] = ~lanes[j];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("drop_in_norm", 64'(drop_err), 64'd1);
        goto_cycle(t + 30);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_drop_err", 64'(drop_err), 64'd0);
        check("abort_out_data_zero", 64'(out_data == '0), 64'd1);
        set_lanes_zero();
        lanes[0] = 32'h0000_0005;
        send(1'b1);
        drain(1'b0);

        // Accept and relatch in the same HOLD cycle.
        out_ready = 1'b0;
        for (int j = 0; j < NUM; j++) lanes[j] = $urandom;
        send(1'b1);
        wait_valid();
        @(posedge clk); #1;
        for (int j = 0; j < NUM; j++) lanes[j] = $urandom;
        for (int j = 0; j < NUM; j++) sq_out[j*32 +: 32] = lanes[j];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sb.push_back(model(cyc + LAT));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain(1'b0);
        @(negedge clk);
        check("b2b_no_drop", 64'(drop_err), 64'd0);

        // Long stall with a dropped pulse in HOLD.
        out_ready = 1'b0;
        for (int j = 0; j < NUM; j++) lanes[j] = $urandom;
        send(1'b1);
        wait_valid();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (k == 50) begin
                for (int j = 0; j < NUM; j++) sq_out[j*32 +: 32] = 32'h1234_5678;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (k == 51) check("drop_in_hold", 64'(drop_err), 64'd1);
        end
        out_ready = 1'b1;
        drain(1'b0);
        @(negedge clk);
        check("drop_sticky", 64'(drop_err), 64'd1);
        check("hold_released", 64'(out_valid), 64'd0);

        pulse_reset();
        @(negedge clk);
        check("final_drop_clear", 64'(drop_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
